// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC source encoding for the fetch PC unit
//
// Purpose : default reset/exception addresses and the next_src_t enum that
//           pc_next_sel reports and pc_unit consumes.
// Contents: PC_RESET_DEFAULT, PC_EXC_DEFAULT, next_src_t.
package pc_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;

  typedef enum logic [2:0] {
    SRC_HOLD = 3'd0,
    SRC_SEQ  = 3'd1,
    SRC_BR   = 3'd2,
    SRC_PEND = 3'd3,
    SRC_ERET = 3'd4,
    SRC_EXC  = 3'd5
  } next_src_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational prioritised next-PC selector
//
// Purpose : picks where the next fetch address comes from, highest first:
//           exception, eret, branch (en=1), buffered redirect (en=1),
//           sequential (en=1), hold (en=0).
// Ports   : en, br_valid, br_target, exc_req, eret_req, epc  - requests
//           pending, pend_target                              - redirect buffer
//           pc, pc_plus4                                      - current PC values
//           next_src                                          - chosen source
//           next_pc                                           - chosen address
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] EXC_PC = WIDTH'(PC_EXC_DEFAULT)
) (
  input  logic             en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             pending,
  input  logic [WIDTH-1:0] pend_target,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus4,
  output next_src_t        next_src,
  output logic [WIDTH-1:0] next_pc
);

  always_comb begin
    next_src = SRC_HOLD;
    next_pc  = pc;
    // Flushes override a stall, so exc/eret are checked before en.
    if (exc_req) begin
      next_src = SRC_EXC;
      next_pc  = EXC_PC;
    end else if (eret_req) begin
      next_src = SRC_ERET;
      next_pc  = epc;
    end else if (en) begin
      if (br_valid) begin
        next_src = SRC_BR;
        next_pc  = br_target;
      end else if (pending) begin
        next_src = SRC_PEND;
        next_pc  = pend_target;
      end else begin
        next_src = SRC_SEQ;
        next_pc  = pc_plus4;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with redirect buffer and optional fetch-address check
//
// Purpose : holds the F-stage PC, a one-entry buffer for redirects that arrive
//           during a stall, and the registered fetch-address-error flag.
// Config  : PC_ALIGN_CHECK_EN defined -> adel registered from the next PC
//           (misaligned or outside [TEXT_LO, TEXT_HI]); undefined -> adel = 0.
// Ports   : clk, reset (sync, active-high)
//           en                      - fetch advance enable (0 = stall)
//           br_valid, br_target     - branch/jump redirect
//           exc_req                 - exception entry
//           eret_req, epc           - exception return
//           PC                      - registered fetch address
//           pc_plus4                - PC + 4 (combinational, wraps)
//           redirect_pending        - buffered redirect waiting
//           adel                    - registered fetch address error
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(PC_EXC_DEFAULT),
  parameter logic [WIDTH-1:0] TEXT_LO  = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TEXT_HI  = WIDTH'(32'h0000_6FFC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect_pending,
  output logic             adel
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             pend_q, pend_d;
  next_src_t        next_src;

  assign pc_plus4 = pc_q + WIDTH'(4);

  pc_next_sel #(
    .WIDTH  (WIDTH),
    .EXC_PC (EXC_PC)
  ) u_next_sel (
    .en          (en),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pending     (pend_q),
    .pend_target (tgt_q),
    .pc          (pc_q),
    .pc_plus4    (pc_plus4),
    .next_src    (next_src),
    .next_pc     (pc_d)
  );

  // Only a stalled, unflushed cycle can leave a redirect waiting; any other
  // source either consumes the buffer or discards it. Latest branch wins.
  always_comb begin
    pend_d = 1'b0;
    tgt_d  = tgt_q;
    if (next_src == SRC_HOLD) begin
      pend_d = pend_q | br_valid;
      if (br_valid) tgt_d = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

  assign PC               = pc_q;
  assign redirect_pending = pend_q;

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q, adel_d;

  // PC still loads the illegal address; downstream exception logic acts on adel.
  assign adel_d = (pc_d[1:0] != 2'b00) || (pc_d < TEXT_LO) || (pc_d > TEXT_HI);

  always_ff @(posedge clk) begin
    if (reset) adel_q <= 1'b0;
    else       adel_q <= adel_d;
  end

  assign adel = adel_q;
`else
  assign adel = 1'b0;
`endif

endmodule
